// File: rtl/cachepool_axi_rd_arbiter.sv
// Shares one downstream AXI read port (AR + R) among NumReq read masters:
// round-robin AR arbitration with an index-prefixed ID, R routing by that prefix.
module cachepool_axi_rd_arbiter #(
  parameter int NumReq         = 2,
  parameter int IdWidth        = 4,
  parameter int AddrWidth      = 48,
  parameter int DataWidth      = 512,
  parameter int MaxOutstanding = 4,
  localparam int OutIdWidth    = IdWidth + $clog2(NumReq)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumReq-1:0]              slv_ar_valid_i,
  output logic [NumReq-1:0]              slv_ar_ready_o,
  input  logic [NumReq*IdWidth-1:0]      slv_ar_id_i,
  input  logic [NumReq*AddrWidth-1:0]    slv_ar_addr_i,
  input  logic [NumReq*8-1:0]            slv_ar_len_i,
  output logic [NumReq-1:0]              slv_r_valid_o,
  input  logic [NumReq-1:0]              slv_r_ready_i,
  output logic [IdWidth-1:0]             slv_r_id_o,
  output logic [DataWidth-1:0]           slv_r_data_o,
  output logic                           slv_r_last_o,
  output logic                           mst_ar_valid_o,
  input  logic                           mst_ar_ready_i,
  output logic [OutIdWidth-1:0]          mst_ar_id_o,
  output logic [AddrWidth-1:0]           mst_ar_addr_o,
  output logic [7:0]                     mst_ar_len_o,
  input  logic                           mst_r_valid_i,
  output logic                           mst_r_ready_o,
  input  logic [OutIdWidth-1:0]          mst_r_id_i,
  input  logic [DataWidth-1:0]           mst_r_data_i,
  input  logic                           mst_r_last_i,
  output logic                           busy_o,
  output logic                           err_o
);

  // Handshakes: a beat transfers on a cycle where valid && ready are both high;
  // once valid rises, valid and payload hold until that cycle.

  localparam int SelWidth = $clog2(NumReq);
  localparam int CntWidth = $clog2(MaxOutstanding + 1);

  typedef enum logic {LOCK_IDLE, LOCK_HELD} lock_state_e;

  lock_state_e         state_q, state_d;
  logic [SelWidth-1:0] lock_idx_q, lock_idx_d;
  logic [SelWidth-1:0] rr_q, rr_d;
  logic [CntWidth-1:0] cnt_q [NumReq];
  logic                err_q;

  logic [NumReq-1:0]   eligible;
  logic [SelWidth-1:0] arb_idx, gnt_idx, cand;
  logic                arb_found, ar_valid, ar_hs;
  int                  rr_pos;

  logic [SelWidth-1:0] r_sel;
  logic                r_sel_ok, r_hs, busy_any;
  logic [NumReq-1:0]   inc, dec;

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      eligible[i] = slv_ar_valid_i[i] && (cnt_q[i] < CntWidth'(MaxOutstanding));
    end
  end

  // First eligible requester at or after the rr pointer, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    rr_pos    = 0;
    cand      = '0;
    for (int k = 0; k < NumReq; k++) begin
      rr_pos = int'(rr_q) + k;
      if (rr_pos >= NumReq) rr_pos = rr_pos - NumReq;
      cand = SelWidth'(rr_pos);
      if (!arb_found && eligible[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign gnt_idx  = (state_q == LOCK_HELD) ? lock_idx_q : arb_idx;
  assign ar_valid = !rst_i && ((state_q == LOCK_HELD) || arb_found);
  assign ar_hs    = ar_valid && mst_ar_ready_i;

  assign mst_ar_valid_o = ar_valid;

  always_comb begin
    slv_ar_ready_o = '0;
    mst_ar_id_o    = '0;
    mst_ar_addr_o  = '0;
    mst_ar_len_o   = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt_idx == SelWidth'(i)) begin
        slv_ar_ready_o[i] = ar_hs;
        mst_ar_id_o       = {SelWidth'(i), slv_ar_id_i[i*IdWidth +: IdWidth]};
        mst_ar_addr_o     = slv_ar_addr_i[i*AddrWidth +: AddrWidth];
        mst_ar_len_o      = slv_ar_len_i[i*8 +: 8];
      end
    end
  end

  // A stalled AR keeps its requester until accepted, whatever the others do.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      LOCK_IDLE: begin
        if (ar_valid && !mst_ar_ready_i) begin
          state_d    = LOCK_HELD;
          lock_idx_d = arb_idx;
        end
      end
      LOCK_HELD: begin
        if (mst_ar_ready_i) state_d = LOCK_IDLE;
      end
      default: state_d = LOCK_IDLE;
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    if (ar_hs) begin
      rr_d = (int'(gnt_idx) == NumReq - 1) ? '0 : gnt_idx + SelWidth'(1);
    end
  end

  assign r_sel        = mst_r_id_i[OutIdWidth-1:IdWidth];
  assign r_sel_ok     = int'(r_sel) < NumReq;
  assign slv_r_id_o   = mst_r_id_i[IdWidth-1:0];
  assign slv_r_data_o = mst_r_data_i;
  assign slv_r_last_o = mst_r_last_i;

  // Beats with an out-of-range prefix are accepted and dropped.
  always_comb begin
    slv_r_valid_o = '0;
    mst_r_ready_o = 1'b1;
    for (int i = 0; i < NumReq; i++) begin
      if (r_sel == SelWidth'(i)) begin
        slv_r_valid_o[i] = mst_r_valid_i && !rst_i;
        mst_r_ready_o    = slv_r_ready_i[i];
      end
    end
  end

  assign r_hs = mst_r_valid_i && mst_r_ready_o;

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      inc[i] = ar_hs && (gnt_idx == SelWidth'(i));
      dec[i] = r_hs && mst_r_last_i && (r_sel == SelWidth'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= LOCK_IDLE;
      lock_idx_q <= '0;
      rr_q       <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NumReq; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
      for (int i = 0; i < NumReq; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt_q[i] <= cnt_q[i] + CntWidth'(1);
        end else if (dec[i] && !inc[i]) begin
          // A return with nothing outstanding is a protocol violation.
          if (cnt_q[i] == '0) err_q <= 1'b1;
          else                cnt_q[i] <= cnt_q[i] - CntWidth'(1);
        end
      end
      if (r_hs && !r_sel_ok) err_q <= 1'b1;
    end
  end

  always_comb begin
    busy_any = 1'b0;
    for (int i = 0; i < NumReq; i++) busy_any = busy_any | (cnt_q[i] != '0);
  end

  assign busy_o = busy_any;
  assign err_o  = err_q;

endmodule

// File: tb/tb_cachepool_axi_rd_arbiter.sv
// Bench for cachepool_axi_rd_arbiter: vector table for arbitration/credits plus
// directed sequences for data routing, simultaneous credit update, reset and errors.
module tb_cachepool_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Two-requester instance
  logic [1:0]   ar_valid, ar_ready_o, r_valid_o, r_ready;
  logic [7:0]   ar_id;
  logic [95:0]  ar_addr;
  logic [15:0]  ar_len;
  logic [3:0]   r_id_o;
  logic [511:0] r_data_o, m_r_data;
  logic         r_last_o, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last;
  logic [4:0]   m_ar_id, m_r_id;
  logic [47:0]  m_ar_addr;
  logic [7:0]   m_ar_len;
  logic         busy, err;

  // Three-requester instance, only its R path is exercised
  logic [2:0]   x_ar_valid, x_ar_ready_o, x_r_valid_o, x_r_ready;
  logic [11:0]  x_ar_id;
  logic [143:0] x_ar_addr;
  logic [23:0]  x_ar_len;
  logic [3:0]   x_r_id_o;
  logic [31:0]  x_r_data_o, x_m_r_data;
  logic         x_r_last_o, x_m_ar_valid, x_m_ar_ready, x_m_r_valid, x_m_r_ready, x_m_r_last;
  logic [5:0]   x_m_ar_id, x_m_r_id;
  logic [47:0]  x_m_ar_addr;
  logic [7:0]   x_m_ar_len;
  logic         x_busy, x_err;

  cachepool_axi_rd_arbiter #(
    .NumReq(2), .IdWidth(4), .AddrWidth(48), .DataWidth(512), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(ar_ready_o), .slv_ar_id_i(ar_id),
    .slv_ar_addr_i(ar_addr), .slv_ar_len_i(ar_len),
    .slv_r_valid_o(r_valid_o), .slv_r_ready_i(r_ready), .slv_r_id_o(r_id_o),
    .slv_r_data_o(r_data_o), .slv_r_last_o(r_last_o),
    .mst_ar_valid_o(m_ar_valid), .mst_ar_ready_i(m_ar_ready), .mst_ar_id_o(m_ar_id),
    .mst_ar_addr_o(m_ar_addr), .mst_ar_len_o(m_ar_len),
    .mst_r_valid_i(m_r_valid), .mst_r_ready_o(m_r_ready), .mst_r_id_i(m_r_id),
    .mst_r_data_i(m_r_data), .mst_r_last_i(m_r_last),
    .busy_o(busy), .err_o(err)
  );

  cachepool_axi_rd_arbiter #(
    .NumReq(3), .IdWidth(4), .AddrWidth(48), .DataWidth(32), .MaxOutstanding(4)
  ) dut3 (
    .clk_i(clk), .rst_i(rst),
    .slv_ar_valid_i(x_ar_valid), .slv_ar_ready_o(x_ar_ready_o), .slv_ar_id_i(x_ar_id),
    .slv_ar_addr_i(x_ar_addr), .slv_ar_len_i(x_ar_len),
    .slv_r_valid_o(x_r_valid_o), .slv_r_ready_i(x_r_ready), .slv_r_id_o(x_r_id_o),
    .slv_r_data_o(x_r_data_o), .slv_r_last_o(x_r_last_o),
    .mst_ar_valid_o(x_m_ar_valid), .mst_ar_ready_i(x_m_ar_ready), .mst_ar_id_o(x_m_ar_id),
    .mst_ar_addr_o(x_m_ar_addr), .mst_ar_len_o(x_m_ar_len),
    .mst_r_valid_i(x_m_r_valid), .mst_r_ready_o(x_m_r_ready), .mst_r_id_i(x_m_r_id),
    .mst_r_data_i(x_m_r_data), .mst_r_last_i(x_m_r_last),
    .busy_o(x_busy), .err_o(x_err)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [511:0] exp_q[$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    ar_valid   = '0;
    m_ar_ready = 1'b0;
    m_r_valid  = 1'b0;
    m_r_id     = '0;
    m_r_data   = '0;
    m_r_last   = 1'b0;
    r_ready    = 2'b11;
    x_ar_valid = '0;
    x_ar_id    = '0;
    x_ar_addr  = '0;
    x_ar_len   = '0;
    x_m_ar_ready = 1'b0;
    x_m_r_valid  = 1'b0;
    x_m_r_id     = '0;
    x_m_r_data   = '0;
    x_m_r_last   = 1'b0;
    x_r_ready    = 3'b111;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [3:0] id, input logic [47:0] addr,
                         input logic [7:0] len);
    ar_id[i*4 +: 4]     = id;
    ar_addr[i*48 +: 48] = addr;
    ar_len[i*8 +: 8]    = len;
  endtask

  task automatic r_beat(input logic [4:0] id, input logic [511:0] data, input logic last);
    m_r_valid = 1'b1;
    m_r_id    = id;
    m_r_data  = data;
    m_r_last  = last;
  endtask

  // Vector table: one cycle each, applied back to back from reset.
  // Requester 0 uses id 3 / addr 0x1000, requester 1 id 5 / addr 0x2000.
  typedef struct packed {
    logic [1:0] ar_valid;
    logic       ar_ready;
    logic       r_valid;
    logic [4:0] r_id;
    logic       r_last;
    logic       exp_ar_valid;
    logic [1:0] exp_ar_ready;
    logic [4:0] exp_ar_id;
    logic [1:0] exp_r_valid;
    logic       exp_r_ready;
    logic       exp_busy;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  logic [511:0] beat_data;

  initial begin
    // contention: alternating grants
    vecs[0]  = '{2'b11, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 2'b01, 5'h03, 2'b00, 1'b1, 1'b0};
    vecs[1]  = '{2'b11, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 2'b10, 5'h15, 2'b00, 1'b1, 1'b1};
    vecs[2]  = '{2'b11, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 2'b01, 5'h03, 2'b00, 1'b1, 1'b1};
    // backpressure: req0 stalled for 5 cycles, req1 arrives mid-stall
    vecs[3]  = '{2'b01, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 2'b00, 5'h03, 2'b00, 1'b1, 1'b1};
    vecs[4]  = '{2'b01, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 2'b00, 5'h03, 2'b00, 1'b1, 1'b1};
    vecs[5]  = '{2'b11, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 2'b00, 5'h03, 2'b00, 1'b1, 1'b1};
    vecs[6]  = '{2'b11, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 2'b00, 5'h03, 2'b00, 1'b1, 1'b1};
    vecs[7]  = '{2'b11, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 2'b00, 5'h03, 2'b00, 1'b1, 1'b1};
    vecs[8]  = '{2'b11, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 2'b01, 5'h03, 2'b00, 1'b1, 1'b1};
    vecs[9]  = '{2'b11, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 2'b10, 5'h15, 2'b00, 1'b1, 1'b1};
    // credit limit on req1 (reaches 4 outstanding)
    vecs[10] = '{2'b10, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 2'b10, 5'h15, 2'b00, 1'b1, 1'b1};
    vecs[11] = '{2'b10, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 2'b10, 5'h15, 2'b00, 1'b1, 1'b1};
    vecs[12] = '{2'b10, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 2'b00, 5'h00, 2'b00, 1'b1, 1'b1};
    vecs[13] = '{2'b11, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 2'b01, 5'h03, 2'b00, 1'b1, 1'b1};
    vecs[14] = '{2'b10, 1'b1, 1'b1, 5'h15, 1'b1, 1'b0, 2'b00, 5'h00, 2'b10, 1'b1, 1'b1};
    vecs[15] = '{2'b10, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 2'b10, 5'h15, 2'b00, 1'b1, 1'b1};
    vecs[16] = '{2'b00, 1'b0, 1'b1, 5'h03, 1'b0, 1'b0, 2'b00, 5'h00, 2'b01, 1'b1, 1'b1};

    ar_id = '0; ar_addr = '0; ar_len = '0;
    drive_idle();

    // Reset state, with requests and a beat already present
    rst = 1'b1;
    set_req(0, 4'h3, 48'h1000, 8'd3);
    set_req(1, 4'h5, 48'h2000, 8'd3);
    ar_valid   = 2'b11;
    m_ar_ready = 1'b1;
    r_beat(5'h03, '0, 1'b1);
    tick();
    tick();
    check("reset_ar_valid", m_ar_valid, 1'b0);
    check("reset_ar_ready", ar_ready_o, 2'b00);
    check("reset_r_valid", r_valid_o, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_x_err", x_err, 1'b0);
    rst = 1'b0;
    drive_idle();

    // Single AR from req0, then a four-beat burst routed back to it
    ar_valid   = 2'b01;
    m_ar_ready = 1'b1;
    settle();
    check("t1_ar_valid", m_ar_valid, 1'b1);
    check("t1_ar_id", m_ar_id, 5'h03);
    check("t1_ar_ready", ar_ready_o, 2'b01);
    check("t1_ar_addr", m_ar_addr, 48'h1000);
    check("t1_ar_len", m_ar_len, 8'd3);
    tick();
    ar_valid   = 2'b00;
    m_ar_ready = 1'b0;
    settle();
    check("t1_busy", busy, 1'b1);
    for (int b = 0; b < 4; b++) begin
      beat_data = {16{$urandom()}};
      exp_q.push_back(beat_data);
      r_beat(5'h03, beat_data, b == 3);
      if (b == 1) begin
        r_ready = 2'b10;
        settle();
        check("t1_stall_ready", m_r_ready, 1'b0);
        tick();
        r_ready = 2'b11;
      end
      settle();
      check($sformatf("t1_b%0d_r_valid", b), r_valid_o, 2'b01);
      check($sformatf("t1_b%0d_r_id", b), r_id_o, 4'h3);
      check($sformatf("t1_b%0d_r_last", b), r_last_o, (b == 3));
      check($sformatf("t1_b%0d_m_r_ready", b), m_r_ready, 1'b1);
      check($sformatf("t1_b%0d_r_data", b), r_data_o, exp_q.pop_front());
      tick();
    end
    m_r_valid = 1'b0;
    m_r_last  = 1'b0;
    settle();
    check("t1_busy_end", busy, 1'b0);

    // Table: contention, lock under backpressure, credit limit
    do_reset();
    for (int v = 0; v < NVEC; v++) begin
      ar_valid   = vecs[v].ar_valid;
      m_ar_ready = vecs[v].ar_ready;
      m_r_valid  = vecs[v].r_valid;
      m_r_id     = vecs[v].r_id;
      m_r_last   = vecs[v].r_last;
      settle();
      check($sformatf("vec%0d_ar_valid", v), m_ar_valid, vecs[v].exp_ar_valid);
      check($sformatf("vec%0d_ar_ready", v), ar_ready_o, vecs[v].exp_ar_ready);
      if (vecs[v].exp_ar_valid) begin
        check($sformatf("vec%0d_ar_id", v), m_ar_id, vecs[v].exp_ar_id);
        check($sformatf("vec%0d_ar_addr", v), m_ar_addr,
              vecs[v].exp_ar_id[4] ? 48'h2000 : 48'h1000);
      end
      check($sformatf("vec%0d_r_valid", v), r_valid_o, vecs[v].exp_r_valid);
      check($sformatf("vec%0d_r_ready", v), m_r_ready, vecs[v].exp_r_ready);
      check($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
      tick();
    end
    drive_idle();

    // AR handshake and RLAST for req0 in the same cycle at two outstanding
    do_reset();
    ar_valid   = 2'b01;
    m_ar_ready = 1'b1;
    tick();
    tick();
    r_beat(5'h03, '0, 1'b1);
    settle();
    check("t5_ar_ready", ar_ready_o, 2'b01);
    check("t5_r_valid", r_valid_o, 2'b01);
    check("t5_r_ready", m_r_ready, 1'b1);
    tick();
    ar_valid   = 2'b00;
    m_ar_ready = 1'b0;
    tick();
    check("t5_busy_one_left", busy, 1'b1);
    tick();
    m_r_valid = 1'b0;
    settle();
    check("t5_busy_drained", busy, 1'b0);
    check("t5_err", err, 1'b0);

    // Reset mid-burst with req0=1, req1=3 outstanding and a stalled AR
    do_reset();
    ar_valid   = 2'b10;
    m_ar_ready = 1'b1;
    tick();
    tick();
    tick();
    ar_valid = 2'b01;
    tick();
    ar_valid   = 2'b11;
    m_ar_ready = 1'b0;
    r_beat(5'h15, '0, 1'b0);
    settle();
    check("t6_pre_busy", busy, 1'b1);
    check("t6_pre_ar_id", m_ar_id, 5'h15);
    rst = 1'b1;
    tick();
    check("t6_rst_ar_valid", m_ar_valid, 1'b0);
    check("t6_rst_r_valid", r_valid_o, 2'b00);
    check("t6_rst_busy", busy, 1'b0);
    rst = 1'b0;
    drive_idle();
    ar_valid   = 2'b11;
    m_ar_ready = 1'b1;
    settle();
    check("t6_post_ar_id", m_ar_id, 5'h03);
    check("t6_post_ar_ready", ar_ready_o, 2'b01);
    tick();
    drive_idle();

    // RLAST with nothing outstanding: saturate and flag
    do_reset();
    r_beat(5'h15, '0, 1'b1);
    settle();
    check("t6_uf_r_valid", r_valid_o, 2'b10);
    tick();
    m_r_valid = 1'b0;
    settle();
    check("t6_uf_err", err, 1'b1);
    check("t6_uf_busy", busy, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_uf_err_cleared", err, 1'b0);

    // Three-requester build: legal prefix 2, then illegal prefix 3
    do_reset();
    x_m_r_valid = 1'b1;
    x_m_r_id    = {2'b10, 4'h1};
    x_r_ready   = 3'b000;
    settle();
    check("x_legal_r_valid", x_r_valid_o, 3'b100);
    check("x_legal_r_ready", x_m_r_ready, 1'b0);
    check("x_legal_r_id", x_r_id_o, 4'h1);
    x_m_r_id  = {2'b11, 4'h7};
    x_r_ready = 3'b111;
    settle();
    check("x_bad_r_valid", x_r_valid_o, 3'b000);
    check("x_bad_r_ready", x_m_r_ready, 1'b1);
    check("x_bad_err_before", x_err, 1'b0);
    tick();
    x_m_r_valid = 1'b0;
    settle();
    check("x_bad_err", x_err, 1'b1);
    tick();
    check("x_bad_err_sticky", x_err, 1'b1);
    check("x_bad_busy", x_busy, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("x_err_cleared", x_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
